// File: rtl/wc_sequencer.sv
// Word-count sequencer: host-writable reload/compare/control registers and a
// step-driven count that pulses tc on each terminal event, then halts or reloads.
module wc_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    input  logic             step,
    input  logic             done,
    output logic [WIDTH-1:0] dowc,
    output logic [WIDTH-1:0] dowcr,
    output logic [WIDTH-1:0] doac,
    output logic [1:0]       mode,
    output logic             wci,
    output logic             tc,
    output logic             running,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_DOWCR = 2'd0;
    localparam logic [1:0] ADDR_DOAC  = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_CMD   = 2'd3;

    localparam logic [1:0] MODE_DOWN    = 2'b00;
    localparam logic [1:0] MODE_COMPARE = 2'b10;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   dowc_q, dowc_d;
    logic [WIDTH-1:0]   dowcr_q, dowcr_d;
    logic [WIDTH-1:0]   doac_q, doac_d;
    logic [1:0]         mode_q, mode_d;
    logic               wci_q, wci_d;
    logic               autoinit_q, autoinit_d;
    logic               tc_q, tc_d;

    logic               wr_dowcr;
    logic               wr_doac;
    logic               wr_ctrl;
    logic               wr_cmd;
    logic               cmd_stop;
    logic               cmd_start;
    logic               step_taken;
    logic               apply_count;
    logic [WIDTH-1:0]   start_value;
    logic [WIDTH-1:0]   count_next;

    assign wr_dowcr  = wr && (addr == ADDR_DOWCR);
    assign wr_doac   = wr && (addr == ADDR_DOAC);
    assign wr_ctrl   = wr && (addr == ADDR_CTRL);
    assign wr_cmd    = wr && (addr == ADDR_CMD);
    assign cmd_stop  = wr_cmd && din[1];
    assign cmd_start = wr_cmd && din[0];

    // Any command write owns the cycle, so a coincident step is dropped.
    assign step_taken = step && (state_q == ST_RUN) && !wr_cmd;

    assign start_value = (mode_q == MODE_DOWN) ? dowcr_q : '0;
    assign count_next  = (mode_q == MODE_DOWN) ? dowc_q - 1'b1 : dowc_q + 1'b1;

    // Modes 00/01 with wci = 0 reach the target on this step; otherwise the
    // terminal step is one past the target and the count holds.
    assign apply_count = (mode_q != MODE_COMPARE) && !wci_q;

    // NOTE: every _d gets its hold value first so this block can never infer a latch.
    always_comb begin
        state_d    = state_q;
        dowc_d     = dowc_q;
        dowcr_d    = dowcr_q;
        doac_d     = doac_q;
        mode_d     = mode_q;
        wci_d      = wci_q;
        autoinit_d = autoinit_q;
        tc_d       = 1'b0;

        if (wr_dowcr) begin
            dowcr_d = din;
        end
        if (wr_doac) begin
            doac_d = din;
        end
        if (wr_ctrl && (state_q != ST_RUN)) begin
            mode_d     = din[1:0];
            wci_d      = din[2];
            autoinit_d = din[3];
        end

        if (cmd_stop) begin
            state_d = ST_IDLE;
        end else if (cmd_start) begin
            state_d = ST_RUN;
            dowc_d  = start_value;
        end else if (step_taken) begin
            if (!done) begin
                dowc_d = count_next;
            end else begin
                tc_d = 1'b1;
                if (autoinit_q) begin
                    dowc_d = start_value;
                end else begin
                    state_d = ST_HALT;
                    if (apply_count) begin
                        dowc_d = count_next;
                    end
                end
            end
        end
    end

    // NOTE: non-blocking assignments only here, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dowc_q     <= '0;
            dowcr_q    <= '0;
            doac_q     <= '0;
            mode_q     <= 2'b00;
            wci_q      <= 1'b0;
            autoinit_q <= 1'b0;
            tc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            dowc_q     <= dowc_d;
            dowcr_q    <= dowcr_d;
            doac_q     <= doac_d;
            mode_q     <= mode_d;
            wci_q      <= wci_d;
            autoinit_q <= autoinit_d;
            tc_q       <= tc_d;
        end
    end

    assign dowc    = dowc_q;
    assign dowcr   = dowcr_q;
    assign doac    = doac_q;
    assign mode    = mode_q;
    assign wci     = wci_q;
    assign tc      = tc_q;
    assign running = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_wc_sequencer.sv
// Bench for wc_sequencer: a comparator model drives done, directed table and
// hand sequences cover the scenarios, then random traffic runs against a model.
module tb_wc_sequencer;

    logic       clk;
    logic       rst;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;
    logic       step;
    logic       done;
    logic [7:0] dowc;
    logic [7:0] dowcr;
    logic [7:0] doac;
    logic [1:0] mode;
    logic       wci;
    logic       tc;
    logic       running;
    logic       halted;

    int n_checks = 0;
    int n_fail   = 0;

    wc_sequencer #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .addr    (addr),
        .din     (din),
        .step    (step),
        .done    (done),
        .dowc    (dowc),
        .dowcr   (dowcr),
        .doac    (doac),
        .mode    (mode),
        .wci     (wci),
        .tc      (tc),
        .running (running),
        .halted  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream terminal-count comparator.
    function automatic logic comp_done(input logic [7:0] c, input logic [7:0] r,
                                       input logic [7:0] a, input logic [1:0] m,
                                       input logic w);
        logic [7:0] c_up;
        c_up = c + 8'd1;
        case (m)
            2'b00:   return w ? (c == 8'd0) : (c == 8'd1);
            2'b01:   return w ? (c == r) : (c_up == r);
            2'b10:   return (c == a);
            default: return 1'b0;
        endcase
    endfunction

    assign done = comp_done(dowc, dowcr, doac, mode, wci);

    // Behavioural model of the sequencer.
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic [7:0] m_dowc, m_dowcr, m_doac;
    logic [1:0] m_mode;
    logic       m_wci, m_auto, m_tc;
    int         m_state;

    task automatic model_reset();
        m_dowc = 8'd0; m_dowcr = 8'd0; m_doac = 8'd0;
        m_mode = 2'b00; m_wci = 1'b0; m_auto = 1'b0; m_tc = 1'b0;
        m_state = S_IDLE;
    endtask

    task automatic model_step(input logic w, input logic [1:0] a,
                              input logic [7:0] d, input logic s);
        logic       dn;
        logic [7:0] start_v;
        logic [7:0] counted;
        int         old_state;
        dn        = comp_done(m_dowc, m_dowcr, m_doac, m_mode, m_wci);
        start_v   = (m_mode == 2'b00) ? m_dowcr : 8'd0;
        counted   = (m_mode == 2'b00) ? m_dowc - 8'd1 : m_dowc + 8'd1;
        old_state = m_state;
        m_tc      = 1'b0;
        if (w && a == 2'd3) begin
            if (d[1]) m_state = S_IDLE;
            else if (d[0]) begin
                m_state = S_RUN;
                m_dowc  = start_v;
            end
        end else if (s && old_state == S_RUN) begin
            if (!dn) m_dowc = counted;
            else begin
                m_tc = 1'b1;
                if (m_auto) m_dowc = start_v;
                else begin
                    m_state = S_HALT;
                    if (m_mode != 2'b10 && !m_wci) m_dowc = counted;
                end
            end
        end
        if (w && a == 2'd0) m_dowcr = d;
        if (w && a == 2'd1) m_doac = d;
        if (w && a == 2'd2 && old_state != S_RUN) begin
            m_mode = d[1:0];
            m_wci  = d[2];
            m_auto = d[3];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_dut();
        return {2'b00, dowc, dowcr, doac, mode, wci, tc, running, halted};
    endfunction

    function automatic logic [31:0] pack_model();
        logic r, h;
        r = (m_state == S_RUN);
        h = (m_state == S_HALT);
        return {2'b00, m_dowc, m_dowcr, m_doac, m_mode, m_wci, m_tc, r, h};
    endfunction

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic apply(input logic w, input logic [1:0] a, input logic [7:0] d, input logic s);
        wr = w; addr = a; din = d; step = s;
        model_step(w, a, d, s);
        @(posedge clk);
        #1;
        wr = 1'b0; step = 1'b0; addr = 2'd0; din = 8'd0;
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] din;
        logic       step;
        logic [7:0] exp_dowc;
        logic       exp_tc;
        logic       exp_running;
        logic       exp_halted;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int tc_count;
        int tc_seen;
        logic [7:0] up_seq[8];

        rst = 1'b1; wr = 1'b0; addr = 2'd0; din = 8'd0; step = 1'b0;
        model_reset();

        // Reset state.
        #12;
        check("reset_all", pack_dut(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_all", pack_dut(), pack_model());

        // Scenario 1: down-count, terminal on reaching 0.
        tbl[0] = '{1'b1, 2'd0, 8'h03, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'd2, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2'd3, 8'h01, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].step);
            check($sformatf("s1_row%0d", i),
                  32'({dowc, tc, running, halted}),
                  32'({tbl[i].exp_dowc, tbl[i].exp_tc, tbl[i].exp_running, tbl[i].exp_halted}));
        end

        // Scenario 2: wci = 1, terminal one step past 0.
        apply(1'b1, 2'd2, 8'h04, 1'b0);
        apply(1'b1, 2'd3, 8'h01, 1'b0);
        check("s2_start", 32'(dowc), 32'd3);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2'd0, 8'h00, 1'b1);
            check($sformatf("s2_step%0d", i), 32'({dowc, tc}), 32'({8'(2 - i), 1'b0}));
        end
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        check("s2_terminal", 32'({dowc, tc, running, halted}), 32'({8'd0, 1'b1, 1'b0, 1'b1}));

        // Scenario 3: up-count with autoinit.
        apply(1'b1, 2'd0, 8'h04, 1'b0);
        apply(1'b1, 2'd2, 8'h09, 1'b0);
        apply(1'b1, 2'd3, 8'h01, 1'b0);
        check("s3_start", 32'(dowc), 32'd0);
        up_seq = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        tc_count = 0;
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 2'd0, 8'h00, 1'b1);
            if (tc) tc_count++;
            check($sformatf("s3_step%0d", i), 32'({dowc, tc, running}),
                  32'({up_seq[i], (i % 4 == 3) ? 1'b1 : 1'b0, 1'b1}));
        end
        check("s3_tc_count", 32'(tc_count), 32'd2);

        // Scenario 4a: compare mode holds at doac.
        apply(1'b1, 2'd3, 8'h02, 1'b0);
        check("s4_stop", 32'({running, halted}), 32'd0);
        apply(1'b1, 2'd1, 8'h02, 1'b0);
        apply(1'b1, 2'd2, 8'h02, 1'b0);
        apply(1'b1, 2'd3, 8'h01, 1'b0);
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        check("s4_pre_terminal", 32'({dowc, tc}), 32'({8'd2, 1'b0}));
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        check("s4_terminal", 32'({dowc, tc, halted}), 32'({8'd2, 1'b1, 1'b1}));

        // Scenario 4b: free-running mode 11 wraps without tc.
        apply(1'b1, 2'd2, 8'h03, 1'b0);
        apply(1'b1, 2'd3, 8'h01, 1'b0);
        tc_seen = 0;
        for (int i = 0; i < 254; i++) begin
            apply(1'b0, 2'd0, 8'h00, 1'b1);
            if (tc) tc_seen++;
        end
        check("s4_reach_fe", 32'(dowc), 32'hFE);
        up_seq[0] = 8'hFF; up_seq[1] = 8'h00; up_seq[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2'd0, 8'h00, 1'b1);
            if (tc) tc_seen++;
            check($sformatf("s4_wrap%0d", i), 32'(dowc), 32'(up_seq[i]));
        end
        check("s4_no_tc", 32'(tc_seen), 32'd0);

        // Scenario 5: command priority and control gating.
        apply(1'b1, 2'd3, 8'h01, 1'b1);
        check("s5_start_drops_step", 32'({dowc, running}), 32'({8'd0, 1'b1}));
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        check("s5_step_after", 32'(dowc), 32'd1);
        apply(1'b1, 2'd2, 8'h00, 1'b0);
        check("s5_ctrl_gated", 32'({mode, running}), 32'({2'b11, 1'b1}));
        apply(1'b1, 2'd3, 8'h03, 1'b0);
        check("s5_stop_wins", 32'({dowc, running, halted}), 32'({8'd1, 1'b0, 1'b0}));
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        check("s5_idle_step", 32'(dowc), 32'd1);

        // Scenario 6: async reset mid-run, then with tc high.
        apply(1'b1, 2'd2, 8'h00, 1'b0);
        apply(1'b1, 2'd0, 8'h08, 1'b0);
        apply(1'b1, 2'd3, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 2'd0, 8'h00, 1'b1);
        check("s6_pre_reset", 32'({dowc, running}), 32'({8'd5, 1'b1}));
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("s6_reset_immediate", pack_dut(), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(1'b1, 2'd0, 8'h01, 1'b0);
        apply(1'b1, 2'd3, 8'h01, 1'b0);
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        check("s6_tc_before_reset", 32'(tc), 32'd1);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("s6_tc_drops", 32'({tc, dowc, dowcr}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        apply(1'b0, 2'd0, 8'h00, 1'b1);
        check("s6_steps_ignored", pack_dut(), pack_model());
        check("s6_still_idle", 32'({dowc, running}), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic       w;
            logic [1:0] a;
            logic [7:0] d;
            logic       s;
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 1) == 1);
            if (w && a == 2'd0) d = 8'($urandom_range(0, 9));
            if (w && a == 2'd1) d = 8'($urandom_range(0, 9));
            apply(w, a, d, s);
            check($sformatf("random%0d", i), pack_dut(), pack_model());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
